// File: rtl/alu_pkg.sv
// Shared ALU types: the result width and the signed result type used by the
// ALU, its result sink and their benches.
package alu_pkg;

   localparam int ALU_RES_W = 6;

   typedef logic signed [ALU_RES_W-1:0] alu_res_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with synchronous flush and occupancy output.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module sync_fifo #(
   parameter int WIDTH = 6,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   input  logic [WIDTH-1:0]           wdata_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     level_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             doPush;
   logic             doPop;

   assign full_o  = (level_q == LVL_W'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign rdata_o = empty_o ? '0 : mem_q[rdPtr_q];

   // A flush swallows any same-cycle push or pop; a push into a full FIFO
   // is only legal when the head leaves in the same cycle.
   assign doPop  = pop_i && !empty_o && !flush_i;
   assign doPush = push_i && (!full_o || doPop) && !flush_i;

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      level_d = level_q;
      if (flush_i) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         level_d = '0;
      end else begin
         if (doPush) wrPtr_d = wrPtr_q + 1'b1;
         if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
         if (doPush && !doPop)      level_d = level_q + 1'b1;
         else if (doPop && !doPush) level_d = level_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         level_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         level_q <= level_d;
      end
   end

   // Storage carries no reset; stale entries are never visible while empty.
   always_ff @(posedge clk) begin
      if (doPush) mem_q[wrPtr_q] <= wdata_i;
   end

endmodule

// File: rtl/alu_result_sink.sv
// Buffers ALU results (which arrive without backpressure) in a FIFO and hands
// them downstream over valid/ready, keeping saturating receive/drop counts.
module alu_result_sink
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic signed [ALU_RES_W-1:0] C,
   input  logic                        C_en,
   input  logic                        flush,
   output logic signed [ALU_RES_W-1:0] out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        full,
   output logic [$clog2(DEPTH):0]      level,
   output logic [CNT_W-1:0]            rcv_cnt,
   output logic [CNT_W-1:0]            drop_cnt
);

   logic                 empty;
   logic                 pop;
   logic                 push;
   logic                 drop;
   logic [ALU_RES_W-1:0] headData;
   logic [CNT_W-1:0]     rcvCnt_q, rcvCnt_d;
   logic [CNT_W-1:0]     dropCnt_q, dropCnt_d;

   assign out_valid = !empty;
   assign out_data  = headData;
   assign pop       = out_valid && out_ready;
   assign push      = C_en && (!full || pop);
   assign drop      = C_en && full && !pop;
   assign rcv_cnt   = rcvCnt_q;
   assign drop_cnt  = dropCnt_q;

   sync_fifo #(
      .WIDTH (ALU_RES_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (flush),
      .wdata_i (C),
      .rdata_o (headData),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level)
   );

   // Events discarded by a flush are not counted; counters stick at all-ones.
   always_comb begin
      rcvCnt_d  = rcvCnt_q;
      dropCnt_d = dropCnt_q;
      if (!flush) begin
         if (push && (rcvCnt_q != '1))  rcvCnt_d  = rcvCnt_q + 1'b1;
         if (drop && (dropCnt_q != '1)) dropCnt_d = dropCnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rcvCnt_q  <= '0;
         dropCnt_q <= '0;
      end else begin
         rcvCnt_q  <= rcvCnt_d;
         dropCnt_q <= dropCnt_d;
      end
   end

endmodule

// File: tb/tb_alu_result_sink.sv
// Self-checking bench for alu_result_sink: a queue of expected results is
// filled as pushes are driven and drained as the DUT hands results out.
module tb_alu_result_sink;
   import alu_pkg::*;

   localparam int DEPTH   = 4;
   localparam int CNT_W   = 8;
   localparam int LVL_W   = $clog2(DEPTH) + 1;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   alu_res_t         C;
   logic             C_en;
   logic             flush;
   alu_res_t         out_data;
   logic             out_valid;
   logic             out_ready;
   logic             full;
   logic [LVL_W-1:0] level;
   logic [CNT_W-1:0] rcv_cnt;
   logic [CNT_W-1:0] drop_cnt;

   int       checks   = 0;
   int       failures = 0;
   alu_res_t sbQ[$];
   int       expRcv;
   int       expDrop;

   alu_result_sink #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .C         (C),
      .C_en      (C_en),
      .flush     (flush),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .full      (full),
      .level     (level),
      .rcv_cnt   (rcv_cnt),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   // Drives one cycle and advances the model. Reports whether the model
   // expected a pop and what the DUT was presenting before the edge.
   task automatic applyStimulus(input logic en, input alu_res_t c, input logic rdy,
                                output bit popped, output alu_res_t act);
      bit pushed;
      popped = (sbQ.size() > 0) && rdy;
      pushed = en && ((sbQ.size() < DEPTH) || popped);
      act    = out_data;
      C_en      = en;
      C         = c;
      out_ready = rdy;
      @(posedge clk); #1;
      if (pushed) begin
         sbQ.push_back(c);
         if (expRcv < CNT_MAX) expRcv++;
      end else if (en) begin
         if (expDrop < CNT_MAX) expDrop++;
      end
      C_en      = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic applyReset();
      rst = 1'b1; C_en = 1'b0; C = '0; flush = 1'b0; out_ready = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0;
      sbQ.delete();
      expRcv  = 0;
      expDrop = 0;
   endtask

   task automatic applyFlush(input logic en, input alu_res_t c, input logic rdy);
      flush = 1'b1; C_en = en; C = c; out_ready = rdy;
      @(posedge clk); #1;
      flush = 1'b0; C_en = 1'b0; out_ready = 1'b0;
      sbQ.delete();
   endtask

   task automatic test_reset();
      applyReset();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
      checks++;
      if (full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
      checks++;
      if (level !== '0) begin failures++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
      checks++;
      if (out_data !== '0) begin failures++; $display("[TB] FAIL reset_data: got %0d expected 0", out_data); end
      checks++;
      if (rcv_cnt !== '0 || drop_cnt !== '0) begin
         failures++; $display("[TB] FAIL reset_counts: got rcv=%0d drop=%0d expected 0/0", rcv_cnt, drop_cnt);
      end
   endtask

   task automatic test_in_order();
      alu_res_t vals[4];
      bit popped;
      alu_res_t act, exp;
      vals[0] = 6'sd5; vals[1] = -6'sd3; vals[2] = 6'sd31; vals[3] = -6'sd32;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) applyStimulus(1'b1, vals[i], 1'b1, popped, act);
         else       applyStimulus(1'b0, '0, 1'b1, popped, act);
         if (popped) begin
            exp = sbQ.pop_front();
            checks++;
            if (act !== exp) begin failures++; $display("[TB] FAIL order_pop: got %0d expected %0d", act, exp); end
         end
         if (i < 4) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== vals[i]) begin
               failures++; $display("[TB] FAIL order_head: got valid=%b data=%0d expected 1/%0d", out_valid, out_data, vals[i]);
            end
         end
      end
      checks++;
      if (rcv_cnt !== CNT_W'(4)) begin failures++; $display("[TB] FAIL order_rcv: got %0d expected 4", rcv_cnt); end
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0) begin
         failures++; $display("[TB] FAIL order_empty: got valid=%b data=%0d expected 0/0", out_valid, out_data);
      end
   endtask

   task automatic test_overflow();
      bit popped;
      alu_res_t act, exp;
      for (int i = 1; i <= 6; i++) begin
         applyStimulus(1'b1, alu_res_t'(i), 1'b0, popped, act);
         if (i == 4) begin
            checks++;
            if (full !== 1'b1) begin failures++; $display("[TB] FAIL ovf_full: got %b expected 1", full); end
         end
      end
      checks++;
      if (drop_cnt !== CNT_W'(expDrop) || expDrop != 2) begin
         failures++; $display("[TB] FAIL ovf_drop: got %0d expected 2", drop_cnt);
      end
      checks++;
      if (level !== LVL_W'(4)) begin failures++; $display("[TB] FAIL ovf_level: got %0d expected 4", level); end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, '0, 1'b1, popped, act);
         if (popped) begin
            exp = sbQ.pop_front();
            checks++;
            if (act !== exp) begin failures++; $display("[TB] FAIL ovf_drain: got %0d expected %0d", act, exp); end
         end
      end
   endtask

   task automatic test_full_push_pop();
      bit popped;
      alu_res_t act, exp;
      for (int i = 10; i < 14; i++) applyStimulus(1'b1, alu_res_t'(i), 1'b0, popped, act);
      applyStimulus(1'b1, -6'sd7, 1'b1, popped, act);
      if (popped) begin
         exp = sbQ.pop_front();
         checks++;
         if (act !== exp) begin failures++; $display("[TB] FAIL fpp_pop: got %0d expected %0d", act, exp); end
      end
      checks++;
      if (level !== LVL_W'(4) || full !== 1'b1) begin
         failures++; $display("[TB] FAIL fpp_level: got level=%0d full=%b expected 4/1", level, full);
      end
      checks++;
      if (drop_cnt !== CNT_W'(expDrop)) begin failures++; $display("[TB] FAIL fpp_drop: got %0d expected %0d", drop_cnt, expDrop); end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, '0, 1'b1, popped, act);
         if (popped) begin
            exp = sbQ.pop_front();
            checks++;
            if (act !== exp) begin failures++; $display("[TB] FAIL fpp_drain: got %0d expected %0d", act, exp); end
         end
      end
   endtask

   task automatic test_flush();
      bit popped;
      alu_res_t act, exp;
      for (int i = 20; i < 23; i++) applyStimulus(1'b1, alu_res_t'(i), 1'b0, popped, act);
      applyFlush(1'b1, 6'sd9, 1'b1);
      checks++;
      if (level !== '0 || out_valid !== 1'b0 || out_data !== '0) begin
         failures++; $display("[TB] FAIL flush_state: got level=%0d valid=%b data=%0d expected 0/0/0", level, out_valid, out_data);
      end
      checks++;
      if (rcv_cnt !== CNT_W'(expRcv)) begin failures++; $display("[TB] FAIL flush_rcv: got %0d expected %0d", rcv_cnt, expRcv); end
      applyStimulus(1'b1, -6'sd1, 1'b0, popped, act);
      checks++;
      if (out_data !== -6'sd1 || level !== LVL_W'(1)) begin
         failures++; $display("[TB] FAIL flush_resume: got data=%0d level=%0d expected -1/1", out_data, level);
      end
      applyStimulus(1'b0, '0, 1'b1, popped, act);
      if (popped) begin
         exp = sbQ.pop_front();
         checks++;
         if (act !== exp) begin failures++; $display("[TB] FAIL flush_drain: got %0d expected %0d", act, exp); end
      end
   endtask

   task automatic test_reset_midstream();
      bit popped;
      alu_res_t act, exp;
      applyStimulus(1'b1, 6'sd3, 1'b0, popped, act);
      applyStimulus(1'b1, 6'sd4, 1'b0, popped, act);
      applyReset();
      checks++;
      if (out_valid !== 1'b0 || level !== '0 || full !== 1'b0 || out_data !== '0 || rcv_cnt !== '0 || drop_cnt !== '0) begin
         failures++;
         $display("[TB] FAIL midrst_zero: got valid=%b level=%0d full=%b data=%0d rcv=%0d drop=%0d expected all 0",
                  out_valid, level, full, out_data, rcv_cnt, drop_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         if (i == 0)      applyStimulus(1'b1, 6'sd7, 1'b1, popped, act);
         else if (i == 1) applyStimulus(1'b1, -6'sd8, 1'b1, popped, act);
         else             applyStimulus(1'b0, '0, 1'b1, popped, act);
         if (popped) begin
            exp = sbQ.pop_front();
            checks++;
            if (act !== exp) begin failures++; $display("[TB] FAIL midrst_resume: got %0d expected %0d", act, exp); end
         end
      end
      checks++;
      if (rcv_cnt !== CNT_W'(2)) begin failures++; $display("[TB] FAIL midrst_rcv: got %0d expected 2", rcv_cnt); end
   endtask

   task automatic test_saturation();
      bit popped;
      alu_res_t act, exp;
      applyReset();
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, alu_res_t'(i), 1'b0, popped, act);
      for (int i = 1; i <= 300; i++) begin
         applyStimulus(1'b1, alu_res_t'(i), 1'b0, popped, act);
         if (i == 254) begin
            checks++;
            if (drop_cnt !== CNT_W'(254)) begin failures++; $display("[TB] FAIL sat_pre: got %0d expected 254", drop_cnt); end
         end
      end
      checks++;
      if (drop_cnt !== CNT_W'(CNT_MAX) || expDrop != CNT_MAX) begin
         failures++; $display("[TB] FAIL sat_drop: got %0d expected %0d", drop_cnt, CNT_MAX);
      end
      checks++;
      if (rcv_cnt !== CNT_W'(4)) begin failures++; $display("[TB] FAIL sat_rcv: got %0d expected 4", rcv_cnt); end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, '0, 1'b1, popped, act);
         if (popped) begin
            exp = sbQ.pop_front();
            checks++;
            if (act !== exp) begin failures++; $display("[TB] FAIL sat_drain: got %0d expected %0d", act, exp); end
         end
      end
   endtask

   task automatic test_back_to_back();
      bit popped;
      alu_res_t act, exp;
      for (int i = 0; i < 13; i++) begin
         if (i < 12) applyStimulus(1'b1, alu_res_t'($urandom_range(0, 63)), 1'b1, popped, act);
         else        applyStimulus(1'b0, '0, 1'b1, popped, act);
         if (popped) begin
            exp = sbQ.pop_front();
            checks++;
            if (act !== exp) begin failures++; $display("[TB] FAIL b2b_pop: got %0d expected %0d", act, exp); end
         end
         if (i > 0 && i < 12) begin
            checks++;
            if (level !== LVL_W'(1) || out_valid !== 1'b1) begin
               failures++; $display("[TB] FAIL b2b_level: got level=%0d valid=%b expected 1/1", level, out_valid);
            end
         end
      end
      checks++;
      if (drop_cnt !== CNT_W'(expDrop) || rcv_cnt !== CNT_W'(expRcv)) begin
         failures++; $display("[TB] FAIL b2b_counts: got rcv=%0d drop=%0d expected %0d/%0d", rcv_cnt, drop_cnt, expRcv, expDrop);
      end
   endtask

   initial begin
      rst = 1'b1; C_en = 1'b0; C = '0; flush = 1'b0; out_ready = 1'b0;
      test_reset();
      test_in_order();
      test_overflow();
      test_full_push_pop();
      test_flush();
      test_reset_midstream();
      test_saturation();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
